add32_sched: RTL and testbench

ADD32_SCHED -- requirements
Module: add32_sched

---
 rtl/add32_sched.sv | 135 +++++++++++++
 tb/tb_add32_sched.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/add32_sched.sv
// rtl/add32_sched.sv - two-requester 32-bit add/sub sequenced over a shared 16-bit adder
//
// Purpose: arbitrates between two requesters (round-robin when both are
// valid), captures one operation, and runs it through an external 16-bit
// adder in two passes: low half, then high half with the carry. The result
// is presented on a valid/ready response port.
//
// Ports:
//   clk, rst_n                  clock (rising edge), async active-low reset
//   reqN_valid/ready            requester N handshake (N = 0, 1)
//   reqN_a, reqN_b, reqN_sub    operands and op select (1 = a-b, 0 = a+b)
//   add_a, add_b, add_cin       operand halves and carry-in to shared adder
//   add_s, add_cout             same-cycle sum and carry-out from shared adder
//   rsp_valid/ready             response handshake
//   rsp_sum, rsp_cout, rsp_ovf  32-bit result, carry-out of bit 31, signed overflow
//   rsp_id                      index of the requester that owns the result

module add32_sched (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req0_sub,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic        req1_sub,
  output logic [15:0] add_a,
  output logic [15:0] add_b,
  output logic        add_cin,
  input  logic [15:0] add_s,
  input  logic        add_cout,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_sum,
  output logic        rsp_cout,
  output logic        rsp_ovf,
  output logic        rsp_id
);

  typedef enum logic [1:0] {IDLE, LO, HI, RESP} state_t;

  state_t      state, state_nxt;
  logic        ptr;          // preferred requester when both are valid
  logic [31:0] op_a;
  logic [31:0] op_b;         // effective b: already inverted for subtraction
  logic        op_cin;
  logic        op_id;
  logic        carry;        // carry out of the low half
  logic        gnt;
  logic        hs;
  logic        sel_sub;
  logic [31:0] sel_a;
  logic [31:0] sel_b;

  always_comb begin
    gnt     = (req0_valid && req1_valid) ? ptr : req1_valid;
    // ready is masked by rst_n so that all outputs read 0 while in reset
    hs      = rst_n && (state == IDLE) && (req0_valid || req1_valid);
    sel_a   = gnt ? req1_a   : req0_a;
    sel_b   = gnt ? req1_b   : req0_b;
    sel_sub = gnt ? req1_sub : req0_sub;
  end

  assign req0_ready = hs && !gnt;
  assign req1_ready = hs && gnt;
  assign rsp_valid  = (state == RESP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    add_a     = 16'h0000;
    add_b     = 16'h0000;
    add_cin   = 1'b0;
    case (state)
      IDLE: if (hs) state_nxt = LO;
      LO: begin
        add_a     = op_a[15:0];
        add_b     = op_b[15:0];
        add_cin   = op_cin;
        state_nxt = HI;
      end
      HI: begin
        add_a     = op_a[31:16];
        add_b     = op_b[31:16];
        add_cin   = carry;
        state_nxt = RESP;
      end
      RESP: if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= 1'b0;
      op_a     <= 32'h0;
      op_b     <= 32'h0;
      op_cin   <= 1'b0;
      op_id    <= 1'b0;
      carry    <= 1'b0;
      rsp_sum  <= 32'h0;
      rsp_cout <= 1'b0;
      rsp_ovf  <= 1'b0;
      rsp_id   <= 1'b0;
    end else begin
      if (hs) begin
        op_a   <= sel_a;
        op_b   <= sel_sub ? ~sel_b : sel_b;
        op_cin <= sel_sub;
        op_id  <= gnt;
        ptr    <= ~gnt;
      end
      if (state == LO) begin
        rsp_sum[15:0] <= add_s;
        carry         <= add_cout;
      end
      if (state == HI) begin
        rsp_sum[31:16] <= add_s;
        rsp_cout       <= add_cout;
        // overflow: operands of equal sign yielding a result of the other sign
        rsp_ovf        <= (op_a[31] == op_b[31]) && (add_s[15] != op_a[31]);
        rsp_id         <= op_id;
      end
    end
  end

endmodule

// File: tb/tb_add32_sched.sv
// tb/tb_add32_sched.sv - directed self-checking bench for add32_sched

module tb_add32_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req0_sub;
  logic [31:0] req0_a, req0_b;
  logic        req1_valid, req1_ready, req1_sub;
  logic [31:0] req1_a, req1_b;
  logic [15:0] add_a, add_b, add_s;
  logic        add_cin, add_cout;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_sum;
  logic        rsp_cout, rsp_ovf, rsp_id;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // shared 16-bit adder outside the block
  assign {add_cout, add_s} = 17'(add_a) + 17'(add_b) + 17'(add_cin);

  add32_sched dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_s(add_s), .add_cout(add_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum),
    .rsp_cout(rsp_cout), .rsp_ovf(rsp_ovf), .rsp_id(rsp_id)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Entered at a negedge with the DUT idle. Operands are scrambled right after
  // the handshake so the result must come from the captured copy.
  task automatic run_op(input logic id, input logic [31:0] a, input logic [31:0] b,
                        input logic sub, input logic [31:0] es, input logic ec,
                        input logic eo, input logic hcin);
    if (id == 1'b0) begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_sub = sub;
    end else begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_sub = sub;
    end
    #1;
    check("hs_ready", id ? req1_ready : req0_ready, 1);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = ~a; req0_b = ~b; req0_sub = ~sub;
    req1_a = ~a; req1_b = ~b; req1_sub = ~sub;
    check("lo_rsp_valid", rsp_valid, 0);
    check("lo_add_a", add_a, a[15:0]);
    @(negedge clk);
    check("hi_rsp_valid", rsp_valid, 0);
    check("hi_add_cin", add_cin, hcin);
    @(negedge clk);
    check("rsp_valid", rsp_valid, 1);
    check("rsp_sum", rsp_sum, es);
    check("rsp_cout", rsp_cout, ec);
    check("rsp_ovf", rsp_ovf, eo);
    check("rsp_id", rsp_id, id);
    if (rsp_ready) begin
      @(negedge clk);
      check("idle_rsp_valid", rsp_valid, 0);
      check("retain_sum", rsp_sum, es);
    end
  endtask

  initial begin
    int n;
    int both;
    int hs_cyc [8];
    logic hs_id [8];
    logic seen;

    rst_n = 1'b0; rsp_ready = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1; req0_sub = 1'b0; req1_sub = 1'b0;
    req0_a = 32'h0; req0_b = 32'h0; req1_a = 32'h0; req1_b = 32'h0;
    repeat (2) @(negedge clk);
    check("rst_req0_ready", req0_ready, 0);
    check("rst_req1_ready", req1_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_sum", rsp_sum, 0);
    check("rst_add", {add_a, add_b, add_cin}, 0);

    // both valid from reset release: grants alternate, 4 cycles apart
    rst_n = 1'b1;
    n = 0; both = 0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      #1;
      if (req0_ready && req1_ready) both++;
      if ((req0_ready || req1_ready) && n < 8) begin
        hs_cyc[n] = cyc; hs_id[n] = req1_ready; n++;
      end
      @(negedge clk);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("rr_both_ready", both, 0);
    check("rr_count", n, 4);
    for (int i = 0; i < 4 && i < n; i++) begin
      check("rr_cycle", hs_cyc[i], 4 * i);
      check("rr_id", hs_id[i], i % 2);
    end

    run_op(1'b0, 32'h0000FFFF, 32'h00000001, 1'b0, 32'h00010000, 1'b0, 1'b0, 1'b1);
    run_op(1'b1, 32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);
    run_op(1'b1, 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b1);
    run_op(1'b0, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1);
    run_op(1'b0, 32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0);

    // stall in RESP for 5 cycles with both requesters asking
    rsp_ready = 1'b0;
    run_op(1'b0, 32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0, 1'b0, 1'b0);
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("stall_valid", rsp_valid, 1);
      check("stall_sum", rsp_sum, 32'h23456789);
      check("stall_flags", {rsp_cout, rsp_ovf, rsp_id}, 0);
      check("stall_ready", {req0_ready, req1_ready}, 0);
      check("stall_add", {add_a, add_b, add_cin}, 0);
      @(negedge clk);
    end
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);
    check("stall_release", rsp_valid, 0);

    // reset during HI; req0 alone leaves the pointer at 1 before reset
    req0_valid = 1'b1; req0_a = 32'h1; req0_b = 32'h2; req0_sub = 1'b0;
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_hi_add_a", add_a, 0);
    check("pre_rst_hi_add_b", add_b, 0);
    rst_n = 1'b0;
    #1;
    check("midrst_rsp_valid", rsp_valid, 0);
    check("midrst_add", {add_a, add_b, add_cin}, 0);
    check("midrst_rsp_sum", rsp_sum, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (rsp_valid) seen = 1'b1;
      @(negedge clk);
    end
    check("postrst_no_rsp", seen, 0);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check("postrst_req0_ready", req0_ready, 1);
    check("postrst_req1_ready", req1_ready, 0);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("postrst_rsp_valid", rsp_valid, 1);
    check("postrst_rsp_sum", rsp_sum, 32'h00000003);
    check("postrst_rsp_id", rsp_id, 0);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
